// File: rtl/alu_core_if.sv
// alu_core_if: operand, control and result bundle between execute and the ALU
interface alu_core_if;
    logic        clk_en;
    logic [4:0]  opcode;
    logic [4:0]  alu_op;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic        bubble_in;
    logic [31:0] flags_restore;
    logic        rfe_in_wb;
    logic [31:0] result;
    logic [3:0]  flags;

    modport master (
        output clk_en, opcode, alu_op, lhs, rhs, bubble_in, flags_restore, rfe_in_wb,
        input  result, flags
    );

    modport slave (
        input  clk_en, opcode, alu_op, lhs, rhs, bubble_in, flags_restore, rfe_in_wb,
        output result, flags
    );
endinterface

// File: rtl/alu_core.sv
// alu_core: 32-bit execute-stage ALU with the architectural {O,S,Z,C} flags register
module alu_core (
    input  logic      clk,
    input  logic      rst,
    alu_core_if.slave bus
);
    logic [3:0]  flags_q, flags_d;
    logic [31:0] res;
    logic        c_in, c_out, o_out, fset;
    logic [4:0]  n;
    logic [63:0] shl, shr, sar, rol, ror;
    logic [32:0] sum, dif;
    logic [31:0] lo_fill, hi_fill;

    assign c_in    = flags_q[0];
    assign n       = bus.rhs[4:0];
    assign fset    = (bus.opcode <= 5'd1) && (bus.alu_op <= 5'd17);
    // Shifting into a double-width word leaves the last bit shifted out just past the result field.
    assign shl     = {32'b0, bus.lhs} << n;
    assign shr     = {bus.lhs, 32'b0} >> n;
    assign sar     = $signed({bus.lhs, 32'b0}) >>> n;
    assign rol     = {bus.lhs, bus.lhs} << n;
    assign ror     = {bus.lhs, bus.lhs} >> n;
    assign lo_fill = c_in ? ~(32'hFFFF_FFFF << n) : 32'b0;
    assign hi_fill = c_in ? ~(32'hFFFF_FFFF >> n) : 32'b0;
    // alu_op[0] distinguishes the carry/borrow-using variants (addc, subb).
    assign sum     = {1'b0, bus.lhs} + {1'b0, bus.rhs} + {32'b0, bus.alu_op[0] & c_in};
    assign dif     = {1'b0, bus.lhs} - {1'b0, bus.rhs} - {32'b0, bus.alu_op[0] & ~c_in};

    // Combinational result plus the carry/overflow the current op would produce.
    always_comb begin
        res   = '0;
        c_out = 1'b0;
        o_out = 1'b0;
        if (bus.opcode <= 5'd1) begin
            case (bus.alu_op)
                5'd0:  res = bus.lhs & bus.rhs;
                5'd1:  res = ~(bus.lhs & bus.rhs);
                5'd2:  res = bus.lhs | bus.rhs;
                5'd3:  res = ~(bus.lhs | bus.rhs);
                5'd4:  res = bus.lhs ^ bus.rhs;
                5'd5:  res = ~(bus.lhs ^ bus.rhs);
                5'd6:  res = ~bus.rhs;
                5'd7:  begin res = shl[31:0];            c_out = shl[32]; end
                5'd8:  begin res = shr[63:32];           c_out = shr[31]; end
                5'd9:  begin res = sar[63:32];           c_out = sar[31]; end
                5'd10: begin res = rol[63:32];           c_out = (n != 5'd0) & rol[32]; end
                5'd11: begin res = ror[31:0];            c_out = (n != 5'd0) & ror[31]; end
                5'd12: begin res = shl[31:0] | lo_fill;  c_out = shl[32]; end
                5'd13: begin res = shr[63:32] | hi_fill; c_out = shr[31]; end
                5'd14, 5'd15: begin
                    res   = sum[31:0];
                    c_out = sum[32];
                    o_out = (bus.lhs[31] == bus.rhs[31]) && (sum[31] != bus.lhs[31]);
                end
                5'd16, 5'd17: begin
                    res   = dif[31:0];
                    c_out = ~dif[32];
                    o_out = (bus.lhs[31] != bus.rhs[31]) && (dif[31] != bus.lhs[31]);
                end
                default: res = '0;
            endcase
        end else if (bus.opcode == 5'd2) begin
            res = bus.rhs;
        end else if (bus.opcode <= 5'd11) begin
            res = bus.lhs + bus.rhs;
        end
    end

    // Next flags: restore on rfe wins, then a live flag-setting op, else hold.
    always_comb begin
        flags_d = flags_q;
        if (bus.clk_en && bus.rfe_in_wb)
            flags_d = bus.flags_restore[3:0];
        else if (bus.clk_en && !bus.bubble_in && fset)
            flags_d = {o_out, res[31], res == '0, c_out};
    end

    // Architectural flags register, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            flags_q <= 4'b0;
        else
            flags_q <= flags_d;
    end

    assign bus.result = res;
    assign bus.flags  = flags_q;
endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed plus random checking of alu_core against a bit-serial reference model
module tb_alu_core;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [3:0] mflags;

    alu_core_if bus();
    alu_core dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [4:0] op, input logic [4:0] fn,
                                  input logic [31:0] a, input logic [31:0] b, input logic cin,
                                  output logic [31:0] r, output logic [3:0] f, output logic fs);
        logic c, o, ci;
        longint ua, ub, sa, sb, t, st;
        int k;
        r = '0; f = '0; fs = 1'b0; c = 1'b0; o = 1'b0;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        k = int'(b[4:0]);
        if (op == 5'd2) r = b;
        else if (op >= 5'd3 && op <= 5'd11) r = 32'(ua + ub);
        else if (op <= 5'd1 && fn <= 5'd17) begin
            fs = 1'b1;
            case (fn)
                5'd0: r = a & b;
                5'd1: r = ~(a & b);
                5'd2: r = a | b;
                5'd3: r = ~(a | b);
                5'd4: r = a ^ b;
                5'd5: r = ~(a ^ b);
                5'd6: r = ~b;
                5'd14, 5'd15: begin
                    ci = (fn == 5'd15) & cin;
                    t = ua + ub + longint'(ci);
                    st = sa + sb + longint'(ci);
                    r = t[31:0]; c = t[32];
                    o = (st > 64'sd2147483647) || (st < -64'sd2147483648);
                end
                5'd16, 5'd17: begin
                    ci = (fn == 5'd17) & ~cin;
                    t = ua - ub - longint'(ci);
                    st = sa - sb - longint'(ci);
                    r = t[31:0]; c = (t >= 0);
                    o = (st > 64'sd2147483647) || (st < -64'sd2147483648);
                end
                default: begin
                    r = a;
                    for (int i = 0; i < k; i++) begin
                        if (fn == 5'd7 || fn == 5'd10 || fn == 5'd12) begin
                            c = r[31];
                            r = {r[30:0], (fn == 5'd10) ? r[31] : (fn == 5'd12) ? cin : 1'b0};
                        end else begin
                            c = r[0];
                            r = {(fn == 5'd9) ? r[31] : (fn == 5'd11) ? r[0] : (fn == 5'd13) ? cin : 1'b0, r[31:1]};
                        end
                    end
                end
            endcase
            f = {o, r[31], r == 32'd0, c};
        end
    endfunction

    task automatic step(input logic en, input logic [4:0] op, input logic [4:0] fn,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic bub, input logic rfe, input logic [31:0] sv);
        logic [31:0] r;
        logic [3:0]  f;
        logic        fs;
        @(negedge clk);
        bus.clk_en = en; bus.opcode = op; bus.alu_op = fn; bus.lhs = a; bus.rhs = b;
        bus.bubble_in = bub; bus.rfe_in_wb = rfe; bus.flags_restore = sv;
        #1;
        model(op, fn, a, b, mflags[0], r, f, fs);
        check($sformatf("result op%0d fn%0d", op, fn), bus.result, r);
        if (en) begin
            if (rfe) mflags = sv[3:0];
            else if (!bub && fs) mflags = f;
        end
        @(posedge clk);
        #1;
        check($sformatf("flags op%0d fn%0d", op, fn), {28'b0, bus.flags}, {28'b0, mflags});
    endtask

    initial begin
        logic [4:0]  op, fn;
        logic [31:0] a, b;
        rst = 1'b1; mflags = 4'b0;
        bus.clk_en = 1'b0; bus.opcode = '0; bus.alu_op = '0; bus.lhs = '0; bus.rhs = '0;
        bus.bubble_in = 1'b0; bus.rfe_in_wb = 1'b0; bus.flags_restore = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_flags", {28'b0, bus.flags}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        step(1, 0, 14, 32'h7FFF_FFFF, 32'd1, 0, 0, 0);
        check("t1_res", bus.result, 32'h8000_0000);
        check("t1_flags", {28'b0, bus.flags}, 32'hC);

        step(1, 1, 16, 32'd5, 32'd5, 0, 0, 0);
        check("t2_zero_flags", {28'b0, bus.flags}, 32'h3);
        step(1, 1, 16, 32'd3, 32'd5, 0, 0, 0);
        check("t2_neg_res", bus.result, 32'hFFFF_FFFE);
        check("t2_neg_flags", {28'b0, bus.flags}, 32'h4);

        step(1, 0, 14, 32'hFFFF_FFFF, 32'd1, 0, 0, 0);
        check("t3_carry_flags", {28'b0, bus.flags}, 32'h3);
        step(1, 0, 15, 32'd2, 32'd3, 0, 0, 0);
        check("t3_addc_flags", {28'b0, bus.flags}, 32'h0);

        step(1, 1, 16, 32'd3, 32'd5, 0, 0, 0);
        step(1, 1, 16, 32'd5, 32'd5, 1, 0, 0);
        check("t4_bubble_hold", {28'b0, bus.flags}, 32'h4);
        step(1, 5, 0, 32'h100, 32'd4, 0, 0, 0);
        check("t4_mem_res", bus.result, 32'h104);
        check("t4_mem_hold", {28'b0, bus.flags}, 32'h4);
        step(0, 1, 16, 32'd5, 32'd5, 0, 0, 0);
        check("t4_en_hold", {28'b0, bus.flags}, 32'h4);

        step(1, 0, 8, 32'h3, 32'd1, 0, 0, 0);
        check("t5_lsr_flags", {28'b0, bus.flags}, 32'h1);
        step(1, 0, 9, 32'h8000_0000, 32'd4, 0, 0, 0);
        check("t5_asr_res", bus.result, 32'hF800_0000);
        step(1, 0, 10, 32'h8000_0001, 32'd1, 0, 0, 0);
        check("t5_rotl_res", bus.result, 32'h0000_0003);

        step(1, 0, 14, 32'd0, 32'd0, 0, 1, 32'hA);
        check("t6_rfe_flags", {28'b0, bus.flags}, 32'hA);
        step(0, 0, 14, 32'd0, 32'd0, 0, 1, 32'h5);
        check("t6_rfe_en_hold", {28'b0, bus.flags}, 32'hA);
        @(negedge clk);
        bus.rfe_in_wb = 1'b0; bus.clk_en = 1'b0;
        #2 rst = 1'b1;
        #1 check("t6_async_rst", {28'b0, bus.flags}, 32'h0);
        mflags = 4'b0;
        rst = 1'b0;

        for (int i = 0; i < 600; i++) begin
            op = ($urandom_range(0, 9) < 7) ? 5'($urandom_range(0, 1)) : 5'($urandom_range(2, 31));
            fn = ($urandom_range(0, 9) < 8) ? 5'($urandom_range(0, 17)) : 5'($urandom_range(18, 31));
            case ($urandom_range(0, 4))
                0: a = 32'h8000_0000;
                1: a = 32'h7FFF_FFFF;
                default: a = $urandom;
            endcase
            b = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
            step(($urandom_range(0, 7) != 0), op, fn, a, b,
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
